// File: rtl/nn_stream_pkg.sv
// Shared types and defaults for the word-serial result stream (nn_axis_result_tx and helpers).
package nn_stream_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned NUM_WORDS_DEF  = 10;
    localparam int unsigned CNT_WIDTH_DEF  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    typedef logic [CNT_WIDTH_DEF-1:0] drop_cnt_t;

    // Counter width able to index n words; never narrower than one bit.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nn_vec_shiftreg.sv
// Vector register with parallel load and word-wise right shift; word 0 sits in the low bits.
module nn_vec_shiftreg
    import nn_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned NUM_WORDS  = NUM_WORDS_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_i,
    input  logic                            shift_i,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] load_data_i,
    output logic [NUM_WORDS*DATA_WIDTH-1:0] vec_o
);

    logic [NUM_WORDS*DATA_WIDTH-1:0] vec_q;

    // Load wins over shift so a back-to-back vector starts cleanly at word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q <= '0;
        end else if (load_i) begin
            vec_q <= load_data_i;
        end else if (shift_i) begin
            vec_q <= vec_q >> DATA_WIDTH;
        end
    end

    assign vec_o = vec_q;

endmodule

// File: rtl/nn_axis_result_tx.sv
// AXI-Stream master serialising the final-layer output vector, neuron 0 first.
// Define NN_AXIS_TX_DOUBLE_BUF_EN to add one pending vector buffer accepted while sending.
module nn_axis_result_tx
    import nn_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned NUM_WORDS  = NUM_WORDS_DEF,
    parameter int unsigned CNT_WIDTH  = $bits(drop_cnt_t)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic                            busy,
    output logic                            tx_done,
    output logic [CNT_WIDTH-1:0]            drop_count
);

    localparam int unsigned VW       = NUM_WORDS * DATA_WIDTH;
    localparam int unsigned WCW      = cnt_bits(NUM_WORDS);
    localparam logic [WCW-1:0] LAST_IDX = WCW'(NUM_WORDS - 1);

    tx_state_t            state_q;
    logic [WCW-1:0]       word_cnt_q;
    logic                 tvalid_q;
    logic                 tlast_q;
    logic                 tx_done_q;
    logic [CNT_WIDTH-1:0] drop_q;

    logic                 beat;
    logic                 last_beat;
    logic                 sh_load;
    logic                 sh_shift;
    logic [VW-1:0]        sh_data;
    logic [VW-1:0]        sh_vec;
    logic                 drop;

`ifdef NN_AXIS_TX_DOUBLE_BUF_EN
    logic                 pend_valid_q;
    logic                 pend_load;
    logic                 pend_take;
    logic [VW-1:0]        pend_vec;

    nn_vec_shiftreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WORDS  (NUM_WORDS)
    ) u_pend (
        .clk         (clk),
        .rst         (rst),
        .load_i      (pend_load),
        .shift_i     (1'b0),
        .load_data_i (in_data),
        .vec_o       (pend_vec)
    );
`endif

    nn_vec_shiftreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WORDS  (NUM_WORDS)
    ) u_shift (
        .clk         (clk),
        .rst         (rst),
        .load_i      (sh_load),
        .shift_i     (sh_shift),
        .load_data_i (sh_data),
        .vec_o       (sh_vec)
    );

    // Vector sourcing: the pending buffer outranks a fresh in_valid at the last beat.
    always_comb begin
        beat      = tvalid_q & m_axis_tready;
        last_beat = beat & tlast_q;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        sh_data   = in_data;
        drop      = 1'b0;
`ifdef NN_AXIS_TX_DOUBLE_BUF_EN
        pend_load = 1'b0;
        pend_take = 1'b0;
`endif
        if (state_q == IDLE) begin
            sh_load = in_valid;
        end else if (last_beat) begin
`ifdef NN_AXIS_TX_DOUBLE_BUF_EN
            if (pend_valid_q) begin
                sh_load   = 1'b1;
                sh_data   = pend_vec;
                pend_take = 1'b1;
                pend_load = in_valid;
            end else begin
                sh_load   = in_valid;
            end
`else
            sh_load = in_valid;
`endif
        end else begin
            sh_shift = beat;
`ifdef NN_AXIS_TX_DOUBLE_BUF_EN
            if (in_valid) begin
                if (pend_valid_q) begin
                    drop = 1'b1;
                end else begin
                    pend_load = 1'b1;
                end
            end
`else
            drop = in_valid;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            word_cnt_q   <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tx_done_q    <= 1'b0;
            drop_q       <= '0;
`ifdef NN_AXIS_TX_DOUBLE_BUF_EN
            pend_valid_q <= 1'b0;
`endif
        end else begin
            tx_done_q <= last_beat;
            if (drop && (drop_q != {CNT_WIDTH{1'b1}})) begin
                drop_q <= drop_q + CNT_WIDTH'(1);
            end
`ifdef NN_AXIS_TX_DOUBLE_BUF_EN
            if (pend_load) begin
                pend_valid_q <= 1'b1;
            end else if (pend_take) begin
                pend_valid_q <= 1'b0;
            end
`endif
            // tlast is precomputed for the word that will be presented next cycle.
            if (sh_load) begin
                state_q    <= SEND;
                tvalid_q   <= 1'b1;
                word_cnt_q <= '0;
                tlast_q    <= (NUM_WORDS == 1);
            end else if (last_beat) begin
                state_q    <= IDLE;
                tvalid_q   <= 1'b0;
                tlast_q    <= 1'b0;
                word_cnt_q <= '0;
            end else if (beat) begin
                word_cnt_q <= word_cnt_q + WCW'(1);
                tlast_q    <= ((word_cnt_q + WCW'(1)) == LAST_IDX);
            end
        end
    end

    assign m_axis_tdata  = sh_vec[DATA_WIDTH-1:0];
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = (state_q == SEND);
    assign tx_done       = tx_done_q;
    assign drop_count    = drop_q;

endmodule
